// File: rtl/ysyx_22041412_lsu_req.sv
//==============================================================================
// Module   : ysyx_22041412_lsu_req
// Purpose  : MEM-stage load/store bus requester, one access outstanding.
//            Optional bus-wait watchdog enabled by macro LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ysyx_22041412_lsu_req #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_wen,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   input  logic [7:0]  mem_wmask,
   output logic        stall_from_mem,
   output logic [63:0] rdata,
   output logic        rdata_valid,
   output logic        access_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [63:0] bus_wdata,
   output logic [7:0]  bus_wmask,
   input  logic        bus_resp_valid,
   input  logic [63:0] bus_resp_data,
   input  logic        bus_resp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;
   logic [63:0] r_rdata;
   logic        r_rdata_valid;
   logic        r_access_err;
   logic        r_req_valid;
   logic        w_timeout;

`ifdef LSU_TIMEOUT_EN
   localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   logic [c_CNT_W-1:0] r_wait_cnt;

   // Counter sits at zero in IDLE, so it is already clear on entry to REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_wait_cnt <= '0;
      end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = (TIMEOUT_CYC == 0);
   assign w_timeout            = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_we          <= 1'b0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wmask       <= '0;
         r_rdata       <= '0;
         r_rdata_valid <= 1'b0;
         r_access_err  <= 1'b0;
         r_req_valid   <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         r_access_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_en) begin
                  r_we        <= mem_wen;
                  r_addr      <= mem_addr;
                  r_wdata     <= mem_wdata;
                  r_wmask     <= mem_wmask;
                  r_req_valid <= 1'b1;
                  r_state     <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_RESP;
               end else if (w_timeout) begin
                  r_req_valid   <= 1'b0;
                  r_rdata       <= '0;
                  r_rdata_valid <= 1'b1;
                  r_access_err  <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            S_RESP: begin
               if (bus_resp_valid) begin
                  r_rdata       <= r_we ? 64'd0 : bus_resp_data;
                  r_rdata_valid <= 1'b1;
                  r_access_err  <= bus_resp_err;
                  r_state       <= S_DONE;
               end else if (w_timeout) begin
                  r_rdata       <= '0;
                  r_rdata_valid <= 1'b1;
                  r_access_err  <= 1'b1;
                  r_state       <= S_DONE;
               end
            end
            // The instruction is still presented here; mem_en must not restart it.
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign stall_from_mem = ((r_state == S_IDLE) && mem_en) ||
                           (r_state == S_REQ) || (r_state == S_RESP);

   assign rdata         = r_rdata;
   assign rdata_valid   = r_rdata_valid;
   assign access_err    = r_access_err;
   assign bus_req_valid = r_req_valid;
   assign bus_we        = r_we;
   assign bus_addr      = r_addr;
   assign bus_wdata     = r_wdata;
   assign bus_wmask     = r_wmask;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041412_lsu_req.sv
//==============================================================================
// Module   : tb_ysyx_22041412_lsu_req
// Purpose  : Directed self-checking bench for the LSU bus requester.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ysyx_22041412_lsu_req;

   logic        clk;
   logic        rst;
   logic        mem_en;
   logic        mem_wen;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        stall_from_mem;
   logic [63:0] rdata;
   logic        rdata_valid;
   logic        access_err;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_resp_valid;
   logic [63:0] bus_resp_data;
   logic        bus_resp_err;

   int n_vec = 0;
   int n_err = 0;
   int n_req_seen = 0;
   int n_rv_seen  = 0;

   ysyx_22041412_lsu_req #(.TIMEOUT_CYC(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_en         (mem_en),
      .mem_wen        (mem_wen),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .stall_from_mem (stall_from_mem),
      .rdata          (rdata),
      .rdata_valid    (rdata_valid),
      .access_err     (access_err),
      .bus_req_valid  (bus_req_valid),
      .bus_req_ready  (bus_req_ready),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_wmask      (bus_wmask),
      .bus_resp_valid (bus_resp_valid),
      .bus_resp_data  (bus_resp_data),
      .bus_resp_err   (bus_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshakes and completion pulses seen at each rising edge.
   always @(posedge clk) begin
      if (bus_req_valid && bus_req_ready) n_req_seen <= n_req_seen + 1;
      if (rdata_valid) n_rv_seen <= n_rv_seen + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; mem_en = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0;
      mem_wmask = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
      bus_resp_data = '0; bus_resp_err = 1'b0;
      tick; tick; #1;
      n_vec++; if ({rdata_valid, access_err, bus_req_valid, stall_from_mem} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b want 0000", {rdata_valid, access_err, bus_req_valid, stall_from_mem}); end
      n_vec++; if (rdata !== 64'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      n_vec++; if ({bus_addr, bus_wdata, bus_wmask, bus_we} !== 137'd0) begin
         n_err++; $display("FAIL reset_fields: got %h %h %h %b want zeros", bus_addr, bus_wdata, bus_wmask, bus_we); end
      tick;
      rst = 1'b0;
   endtask

   task automatic test_load;
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_0010; bus_req_ready = 1'b1; #1;
      n_vec++; if ({stall_from_mem, bus_req_valid} !== 2'b10) begin
         n_err++; $display("FAIL load_idle: stall/valid got %b want 10", {stall_from_mem, bus_req_valid}); end
      tick;
      n_vec++; if ({bus_req_valid, bus_we, stall_from_mem, bus_addr} !== {3'b101, 64'h8000_0010}) begin
         n_err++; $display("FAIL load_req: got %b %h want 101 80000010", {bus_req_valid, bus_we, stall_from_mem}, bus_addr); end
      tick;
      bus_resp_valid = 1'b1; bus_resp_data = 64'hDEAD_BEEF; bus_resp_err = 1'b0; #1;
      n_vec++; if ({stall_from_mem, rdata_valid, bus_req_valid} !== 3'b100) begin
         n_err++; $display("FAIL load_resp: stall/rv/valid got %b want 100", {stall_from_mem, rdata_valid, bus_req_valid}); end
      tick;
      bus_resp_valid = 1'b0; #1;
      n_vec++; if ({rdata_valid, access_err, stall_from_mem, rdata} !== {3'b100, 64'hDEAD_BEEF}) begin
         n_err++; $display("FAIL load_done: got %b %h want 100 deadbeef", {rdata_valid, access_err, stall_from_mem}, rdata); end
      tick;
      mem_en = 1'b0; bus_req_ready = 1'b0; #1;
      n_vec++; if ({rdata_valid, stall_from_mem, rdata} !== {2'b00, 64'hDEAD_BEEF}) begin
         n_err++; $display("FAIL load_hold: got %b %h want 00 deadbeef", {rdata_valid, stall_from_mem}, rdata); end
   endtask

   task automatic test_store;
      mem_en = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_1000;
      mem_wdata = 64'h1122_3344_5566_7788; mem_wmask = 8'hFF; bus_req_ready = 1'b0;
      tick;
      mem_wdata = 64'h0; mem_wmask = 8'h0; mem_addr = 64'h0;
      for (int i = 0; i < 5; i++) begin
         bus_req_ready = (i == 4); #1;
         n_vec++; if ({bus_req_valid, bus_we, bus_addr, bus_wdata, bus_wmask} !==
                      {2'b11, 64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF}) begin
            n_err++; $display("FAIL store_req_stable[%0d]: got %b %h %h %h", i, {bus_req_valid, bus_we}, bus_addr, bus_wdata, bus_wmask); end
         tick;
      end
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'hCAFE_F00D; #1;
      n_vec++; if (bus_req_valid !== 1'b0) begin n_err++; $display("FAIL store_resp_valid: got %b want 0", bus_req_valid); end
      tick;
      bus_resp_valid = 1'b0; #1;
      n_vec++; if ({rdata_valid, access_err, rdata} !== {2'b10, 64'd0}) begin
         n_err++; $display("FAIL store_done: got %b %h want 10 0", {rdata_valid, access_err}, rdata); end
      tick;
      mem_en = 1'b0; mem_wen = 1'b0; #1;
   endtask

   task automatic test_resp_err;
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_0020; bus_req_ready = 1'b1;
      tick; tick;
      bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_data = 64'h55;
      tick;
      bus_resp_valid = 1'b0; bus_resp_err = 1'b0; #1;
      n_vec++; if ({rdata_valid, access_err} !== 2'b11) begin
         n_err++; $display("FAIL err_done: rv/err got %b want 11", {rdata_valid, access_err}); end
      tick;
      mem_en = 1'b0; bus_req_ready = 1'b0; #1;
      n_vec++; if ({rdata_valid, access_err, stall_from_mem, bus_req_valid} !== 4'b0000) begin
         n_err++; $display("FAIL err_after: got %b want 0000", {rdata_valid, access_err, stall_from_mem, bus_req_valid}); end
   endtask

   task automatic test_reset_in_resp;
      bit bad;
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_0030; bus_req_ready = 1'b1;
      tick; tick;
      bus_req_ready = 1'b0; rst = 1'b1;
      tick;
      rst = 1'b0; mem_en = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h77; #1;
      n_vec++; if ({stall_from_mem, rdata_valid, bus_req_valid, rdata} !== {3'b000, 64'd0}) begin
         n_err++; $display("FAIL rst_resp: got %b %h want 000 0", {stall_from_mem, rdata_valid, bus_req_valid}, rdata); end
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         if (rdata_valid !== 1'b0 || stall_from_mem !== 1'b0) bad = 1'b1;
      end
      n_vec++; if (bad) begin n_err++; $display("FAIL rst_resp_discard: got a pulse/stall want none"); end
      bus_resp_valid = 1'b0;
   endtask

   task automatic test_back_to_back;
      int s_req;
      int s_rv;
      s_req = n_req_seen; s_rv = n_rv_seen;
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_0100; bus_req_ready = 1'b1;
      tick; tick;
      bus_resp_valid = 1'b1; bus_resp_data = 64'h1111;
      tick;
      bus_resp_valid = 1'b0; #1;
      n_vec++; if ({rdata_valid, rdata} !== {1'b1, 64'h1111}) begin
         n_err++; $display("FAIL b2b_first: got %b %h want 1 1111", rdata_valid, rdata); end
      tick;
      mem_addr = 64'h8000_0108; #1;
      n_vec++; if (stall_from_mem !== 1'b1) begin n_err++; $display("FAIL b2b_idle_stall: got %b want 1", stall_from_mem); end
      tick;
      n_vec++; if ({bus_req_valid, bus_addr} !== {1'b1, 64'h8000_0108}) begin
         n_err++; $display("FAIL b2b_second_req: got %b %h want 1 80000108", bus_req_valid, bus_addr); end
      tick;
      bus_resp_valid = 1'b1; bus_resp_data = 64'h2222;
      tick;
      bus_resp_valid = 1'b0; #1;
      n_vec++; if ({rdata_valid, rdata} !== {1'b1, 64'h2222}) begin
         n_err++; $display("FAIL b2b_second: got %b %h want 1 2222", rdata_valid, rdata); end
      tick;
      mem_en = 1'b0; bus_req_ready = 1'b0;
      tick; tick;
      n_vec++; if (n_req_seen - s_req !== 2) begin
         n_err++; $display("FAIL b2b_req_count: got %0d want 2", n_req_seen - s_req); end
      n_vec++; if (n_rv_seen - s_rv !== 2) begin
         n_err++; $display("FAIL b2b_rv_count: got %0d want 2", n_rv_seen - s_rv); end
   endtask

   task automatic test_timeout;
      bit bad;
      mem_en = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_0040; bus_req_ready = 1'b0;
      tick;
`ifdef LSU_TIMEOUT_EN
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus_req_valid !== 1'b1 || rdata_valid !== 1'b0) bad = 1'b1;
         tick;
      end
      n_vec++; if (bad) begin n_err++; $display("FAIL to_wait: request dropped or early completion in 8 wait cycles"); end
      n_vec++; if ({rdata_valid, access_err, bus_req_valid, stall_from_mem, rdata} !== {4'b1100, 64'd0}) begin
         n_err++; $display("FAIL to_done: got %b %h want 1100 0", {rdata_valid, access_err, bus_req_valid, stall_from_mem}, rdata); end
      tick;
      mem_en = 1'b0; bus_resp_valid = 1'b1; bus_req_ready = 1'b1; #1;
      tick;
      n_vec++; if ({rdata_valid, bus_req_valid, stall_from_mem} !== 3'b000) begin
         n_err++; $display("FAIL to_late_resp: got %b want 000", {rdata_valid, bus_req_valid, stall_from_mem}); end
      bus_resp_valid = 1'b0; bus_req_ready = 1'b0;
`else
      bad = 1'b0;
      for (int i = 0; i < 120; i++) begin
         if (stall_from_mem !== 1'b1 || bus_req_valid !== 1'b1 || rdata_valid !== 1'b0) bad = 1'b1;
         tick;
      end
      n_vec++; if (bad) begin n_err++; $display("FAIL nto_wait: stall or request dropped within 120 cycles"); end
      bus_req_ready = 1'b1;
      tick;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b1; bus_resp_data = 64'h99;
      tick;
      bus_resp_valid = 1'b0; #1;
      n_vec++; if ({rdata_valid, access_err, rdata} !== {2'b10, 64'h99}) begin
         n_err++; $display("FAIL nto_done: got %b %h want 10 99", {rdata_valid, access_err}, rdata); end
      tick;
      mem_en = 1'b0;
`endif
   endtask

   initial begin
      test_reset;
      test_load;
      test_store;
      test_resp_err;
      test_reset_in_resp;
      test_back_to_back;
      test_timeout;
      tick;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ysyx_22041412_lsu_req.md
YSYX_22041412_LSU_REQ -- requirements
Module: ysyx_22041412_lsu_req

Interface
REQ-001 Parameters SHALL be:
  - TIMEOUT_CYC, default 255: bus-wait limit in cycles; used only with LSU_TIMEOUT_EN.
REQ-002 Ports SHALL be:
  - clk  in  1  clock; all state changes on rising edge.
  - rst  in  1  reset, synchronous, active-high.
  - mem_en  in  1  MEM stage holds a load/store this cycle.
  - mem_wen  in  1  1 = store, 0 = load.
  - mem_addr  in  64  access address.
  - mem_wdata  in  64  store data.
  - mem_wmask  in  8  store byte mask.
  - stall_from_mem  out  1  pipeline freeze request to the stall controller.
  - rdata  out  64  load result.
  - rdata_valid  out  1  one-cycle pulse: access complete.
  - access_err  out  1  one-cycle pulse with rdata_valid: bus error or timeout.
  - bus_req_valid  out  1  request valid.
  - bus_req_ready  in  1  request accepted when high with valid.
  - bus_we  out  1  request is a write.
  - bus_addr  out  64  request address.
  - bus_wdata  out  64  request write data.
  - bus_wmask  out  8  request byte mask.
  - bus_resp_valid  in  1  response present.
  - bus_resp_data  in  64  read data.
  - bus_resp_err  in  1  response error flag.

Function
REQ-003 The FSM SHALL have exactly four states, IDLE, REQ, RESP and DONE, advancing on clk.
REQ-004 In IDLE with mem_en=1, the block SHALL latch mem_wen, mem_addr, mem_wdata and mem_wmask and go to REQ; with mem_en=0 it SHALL remain in IDLE.
REQ-005 stall_from_mem SHALL be combinational: 1 when (IDLE and mem_en) or REQ or RESP; 0 in DONE and in idle-without-request.
REQ-006 In REQ, bus_req_valid SHALL be 1, with bus_we/addr/wdata/wmask driven from the latched values and held stable until bus_req_ready=1; the state SHALL then go to RESP.
REQ-007 bus_req_valid SHALL be 0 in every state other than REQ, and bus_resp_valid SHALL be ignored outside RESP.
REQ-008 In RESP, when bus_resp_valid=1 the block SHALL capture bus_resp_data (loads only) and bus_resp_err, then go to DONE.
REQ-009 In DONE:
  - rdata_valid SHALL be 1 and access_err SHALL equal the captured error.
  - rdata SHALL be the captured data for loads and 0 for stores.
  - mem_en SHALL be ignored (the same instruction is still presented), and the next state SHALL be IDLE.
REQ-010 rdata SHALL hold its value until the next DONE; rdata_valid and access_err SHALL be 0 outside DONE.
REQ-011 Minimum access latency SHALL be 3 cycles from mem_en to rdata_valid: one cycle each in IDLE, REQ and RESP with immediate ready and response.
REQ-012 At most one access SHALL be outstanding; no new request SHALL be issued before DONE.

Reset
REQ-013 With rst=1 at a clock edge, the state SHALL become IDLE and rdata, rdata_valid, access_err, bus_req_valid and the latched fields SHALL become 0, regardless of the current state.
REQ-014 After a reset taken during REQ or RESP, the outstanding response SHALL be discarded, with no rdata_valid pulse.

Configuration
REQ-015 With macro LSU_TIMEOUT_EN defined, a cycle counter SHALL:
  - clear on entry to REQ and count cycles in REQ plus RESP;
  - on reaching TIMEOUT_CYC, force DONE with access_err=1 and rdata=0, and drop bus_req_valid.
  Any later bus_resp_valid SHALL be ignored.
REQ-016 Without LSU_TIMEOUT_EN, no counter SHALL exist, the block SHALL wait indefinitely, and access_err SHALL come only from bus_resp_err.

Verification
REQ-017 Load, mem_en=1 addr=0x80000010, ready and resp immediate with data 0xDEADBEEF -> stall_from_mem high 2 cycles (IDLE, REQ) plus RESP, rdata=0xDEADBEEF and rdata_valid=1 in cycle 3.
REQ-018 Store, wdata=0x1122334455667788 mask=0xFF, ready held low 4 cycles -> bus_req_valid and all fields stable for 5 cycles; DONE shows rdata=0, access_err=0.
REQ-019 Load with bus_resp_err=1 -> rdata_valid=1 and access_err=1 for exactly one cycle, then IDLE.
REQ-020 rst asserted in RESP, followed by bus_resp_valid=1 -> no rdata_valid, and stall_from_mem=0 once mem_en=0.
REQ-021 LSU_TIMEOUT_EN, TIMEOUT_CYC=8, ready never asserted -> DONE after 8 wait cycles with access_err=1 and bus_req_valid=0; without the macro, stall_from_mem stays 1 for 100+ cycles.
REQ-022 Back-to-back loads (mem_en held through DONE, new address the next cycle) -> exactly two bus requests and two rdata_valid pulses.
